// File: rtl/serial_word_adder_pkg.sv
// Shared types and constants for the serial word adder.
// Provides the FSM state type, default sizes and the index-width helper.
package serial_word_adder_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the byte index; a one-byte word still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_word_adder_if.sv
// Start/done handshake and operand/result bus of the serial word adder.
// master: start, word_a, word_b, carry_in out; results and status in.
// slave:  the reverse; used by the adder itself.
interface serial_word_adder_if
    import serial_word_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_BYTES  = DEF_NUM_BYTES
);

    localparam int W = DATA_WIDTH * NUM_BYTES;

    logic         start;
    logic [W-1:0] word_a;
    logic [W-1:0] word_b;
    logic         carry_in;
    logic [W-1:0] word_sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output word_a,
        output word_b,
        output carry_in,
        input  word_sum,
        input  carry_out,
        input  overflow,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  word_a,
        input  word_b,
        input  carry_in,
        output word_sum,
        output carry_out,
        output overflow,
        output busy,
        output done
    );

endinterface

// File: rtl/serial_word_adder_byte_adder.sv
// Combinational DATA_WIDTH-bit adder slice with carry in and carry out.
// Ports: a, b (operand slices), cin, sum (slice result), cout.
module byte_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
);

    logic [DATA_WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
    assign sum  = full[DATA_WIDTH-1:0];
    assign cout = full[DATA_WIDTH];

endmodule

// File: rtl/serial_word_adder.sv
// Adds two NUM_BYTES-slice words one slice per clock through one byte_adder.
// Ports: clk, rst_n (async, active low), bus (slave side of the handshake).
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_BYTES  = DEF_NUM_BYTES
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_word_adder_if.slave  bus
);

    localparam int W  = DATA_WIDTH * NUM_BYTES;
    localparam int IW = idx_width(NUM_BYTES);
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

    state_t state;
    state_t state_nxt;

    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          c_reg;

    logic [W-1:0]  word_sum_r;
    logic          carry_out_r;
    logic          overflow_r;

    logic load;
    logic step;
    logic last;

    int                  lsb;
    logic [DATA_WIDTH-1:0] a_slice;
    logic [DATA_WIDTH-1:0] b_slice;
    logic [DATA_WIDTH-1:0] s_slice;
    logic                  s_cout;
    logic [W-1:0]          sum_next;
    logic                  ovf_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE accepts a new start just like IDLE so start held high
    // yields one result every NUM_BYTES+1 cycles.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign lsb     = int'(idx) * DATA_WIDTH;
    assign a_slice = a_reg[lsb +: DATA_WIDTH];
    assign b_slice = b_reg[lsb +: DATA_WIDTH];

    byte_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (c_reg),
        .sum  (s_slice),
        .cout (s_cout)
    );

    // Sum register with the current slice merged in; on the last RUN
    // cycle this is the complete word, so outputs load from it directly.
    always_comb begin
        sum_next = sum_reg;
        sum_next[lsb +: DATA_WIDTH] = s_slice;
        ovf_next = (a_reg[W-1] == b_reg[W-1])
                && (sum_next[W-1] != a_reg[W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            c_reg       <= 1'b0;
            word_sum_r  <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (load) begin
                a_reg <= bus.word_a;
                b_reg <= bus.word_b;
                c_reg <= bus.carry_in;
                idx   <= '0;
            end else if (step) begin
                sum_reg <= sum_next;
                c_reg   <= s_cout;
                idx     <= idx + 1'b1;
            end
            if (last) begin
                word_sum_r  <= sum_next;
                carry_out_r <= s_cout;
                overflow_r  <= ovf_next;
            end
        end
    end

    assign bus.word_sum  = word_sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_serial_word_adder.sv
// Self-checking bench for serial_word_adder with directed and random words.
// Drives the master side of the interface and checks against a word model.
module tb_serial_word_adder;
    import serial_word_adder_pkg::*;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int W  = DW * NB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_word_adder_if #(.DATA_WIDTH(DW), .NUM_BYTES(NB)) bus ();

    serial_word_adder #(
        .DATA_WIDTH (DW),
        .NUM_BYTES  (NB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: {overflow, carry_out, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] t;
        logic       ov;
        t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {ov, t};
    endfunction

    task automatic scramble();
        bus.word_a   = $urandom;
        bus.word_b   = $urandom;
        bus.carry_in = 1'($urandom_range(1));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic cin);
        logic [W+1:0] e;
        e = model(a, b, cin);
        check({tag, ".sum"}, 64'(bus.word_sum), 64'(e[W-1:0]));
        check({tag, ".cout"}, 64'(bus.carry_out), 64'(e[W]));
        check({tag, ".ovf"}, 64'(bus.overflow), 64'(e[W+1]));
        check({tag, ".busy_in_done"}, 64'(bus.busy), 64'(0));
    endtask

    // Called #1 after a posedge. Runs one operation with start dropped
    // after acceptance; optionally pulses start with all-ones during RUN.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input bit mid);
        int edges;
        int busy_hi;
        logic [W-1:0] held;
        bus.start    = 1'b1;
        bus.word_a   = a;
        bus.word_b   = b;
        bus.carry_in = cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        edges   = 0;
        busy_hi = 0;
        if (mid) begin
            bus.start    = 1'b1;
            bus.word_a   = '1;
            bus.word_b   = '1;
            bus.carry_in = 1'b1;
            if (bus.busy) busy_hi++;
            @(posedge clk);
            #1;
            edges++;
            bus.start = 1'b0;
        end
        while (bus.done !== 1'b1 && edges < 20) begin
            if (bus.busy) busy_hi++;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, ".latency"}, 64'(edges), 64'(NB));
        check({tag, ".busy_cycles"}, 64'(busy_hi), 64'(NB));
        check_result(tag, a, b, cin);
        held = bus.word_sum;
        @(posedge clk);
        #1;
        check({tag, ".done_single"}, 64'(bus.done), 64'(0));
        check({tag, ".hold"}, 64'(bus.word_sum), 64'(held));
    endtask

    initial begin
        logic [W-1:0] qa [3];
        logic [W-1:0] qb [3];
        logic         qc [3];
        int edges;

        bus.start = 1'b0;
        scramble();

        #2;
        check("reset.sum", 64'(bus.word_sum), 64'(0));
        check("reset.cout", 64'(bus.carry_out), 64'(0));
        check("reset.ovf", 64'(bus.overflow), 64'(0));
        check("reset.busy", 64'(bus.busy), 64'(0));
        check("reset.done", 64'(bus.done), 64'(0));
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        run_op("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        run_op("t3a", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op("t3b", 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        run_op("t4", 32'h12345678, 32'h11111111, 1'b0, 1'b1);

        bus.start    = 1'b1;
        bus.word_a   = 32'hDEADBEEF;
        bus.word_b   = 32'h01010101;
        bus.carry_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("t5.in_run", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t5.sum", 64'(bus.word_sum), 64'(0));
        check("t5.cout", 64'(bus.carry_out), 64'(0));
        check("t5.ovf", 64'(bus.overflow), 64'(0));
        check("t5.busy", 64'(bus.busy), 64'(0));
        check("t5.done", 64'(bus.done), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) edges++;
        end
        check("t5.no_done", 64'(edges), 64'(0));
        run_op("t5.after", 32'h1, 32'h1, 1'b0, 1'b0);

        qa[0] = 32'hA5A5A5A5; qb[0] = 32'h5A5A5A5B; qc[0] = 1'b0;
        qa[1] = 32'h40000000; qb[1] = 32'h40000000; qc[1] = 1'b1;
        qa[2] = 32'h0000FFFF; qb[2] = 32'hFFFF0000; qc[2] = 1'b1;
        bus.start    = 1'b1;
        bus.word_a   = qa[0];
        bus.word_b   = qb[0];
        bus.carry_in = qc[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            scramble();
            edges = 0;
            while (bus.done !== 1'b1 && edges < 20) begin
                @(posedge clk);
                #1;
                edges++;
            end
            check($sformatf("t6.gap%0d", k), 64'(edges), 64'(NB));
            check_result($sformatf("t6.op%0d", k), qa[k], qb[k], qc[k]);
            if (k < 2) begin
                bus.word_a   = qa[k+1];
                bus.word_b   = qb[k+1];
                bus.carry_in = qc[k+1];
            end else begin
                bus.start = 1'b0;
            end
        end
        @(posedge clk);
        #1;

        for (int r = 0; r < 10; r++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1));
            run_op($sformatf("rnd%0d", r), ra, rb, rc, 1'(r % 3 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
